// File: rtl/ram_burst_ctrl.sv
// Burst controller that turns write/read burst commands into single-port RAM cycles.
// Optional power-up zero fill of the whole RAM is enabled by defining RAM_CLEAR_EN.
module ram_burst_ctrl #(
  parameter int ADDRESS_SIZE = 10,
  parameter int DATA_SIZE    = 10,
  parameter int MEMORY_SIZE  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESS_SIZE-1:0] cmd_addr,
  input  logic [ADDRESS_SIZE-1:0] cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_SIZE-1:0]    wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_SIZE-1:0]    rd_data,
  output logic                    busy,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic [DATA_SIZE-1:0]    ram_data_in,
  output logic                    ram_write,
  output logic                    ram_chip_select,
  input  logic [DATA_SIZE-1:0]    ram_data_out
);

`ifdef RAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, WRITE = 2'd2, READ = 2'd3} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd2, READ = 2'd3} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(MEMORY_SIZE - 1);

  state_t                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] ptr_q, ptr_d;
  logic [ADDRESS_SIZE-1:0] cnt_q, cnt_d;
  logic                    beat_s;

  // Pointer advance wraps at the configured memory depth, not at the address width.
  function automatic logic [ADDRESS_SIZE-1:0] wrap_inc(input logic [ADDRESS_SIZE-1:0] p);
    if (p == LAST_ADDR) begin
      return '0;
    end else begin
      return p + ADDRESS_SIZE'(1);
    end
  endfunction

  // State, pointer and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and handshake/RAM outputs; every handshake is masked while rst is high.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    beat_s          = 1'b0;
    cmd_ready       = 1'b0;
    wr_ready        = 1'b0;
    rd_valid        = 1'b0;
    rd_data         = '0;
    ram_write       = 1'b0;
    ram_data_in     = '0;
    ram_address     = ptr_q;
    busy            = (state_q != IDLE);
    ram_chip_select = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          ptr_d   = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WRITE : READ;
        end else begin
          state_d = IDLE;
        end
      end
`ifdef RAM_CLEAR_EN
      CLEAR: begin
        ram_write = !rst;
        ptr_d     = wrap_inc(ptr_q);
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
`endif
      WRITE: begin
        wr_ready = !rst;
        beat_s   = wr_valid && !rst;
        if (beat_s) begin
          ram_write   = 1'b1;
          ram_data_in = wr_data;
        end else begin
          ram_write   = 1'b0;
        end
      end
      READ: begin
        rd_valid = !rst;
        rd_data  = ram_data_out;
        beat_s   = rd_ready && !rst;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // cnt holds beats remaining after the current one, so zero marks the last beat.
    if (beat_s) begin
      ptr_d = wrap_inc(ptr_q);
      cnt_d = cnt_q - ADDRESS_SIZE'(1);
      if (cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        state_d = state_q;
      end
    end else begin
      beat_s = 1'b0;
    end
  end

endmodule
